serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 88 ++++++++
 tb/tb_serial_subtractor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor (a - b).
// One full-adder cell with inverted b and a registered carry.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic nb, s, c_nx, last, accept;

  // Full-adder cell: a + ~b + carry, carry seeded with 1
  always_comb begin
    nb     = ~b_sh[0];
    s      = a_sh[0] ^ nb ^ c;
    c_nx   = (a_sh[0] & nb) | (c & (a_sh[0] ^ nb));
    last   = (cnt == CW'(WIDTH - 1));
    accept = start && (state != RUN);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = accept ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      c          <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        c    <= 1'b1;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= {s, r_sh[WIDTH-1:1]};
        c    <= c_nx;
        cnt  <= cnt + 1'b1;
        if (last) begin
          diff       <= {s, r_sh[WIDTH-1:1]};
          borrow_out <= ~c_nx;
          overflow   <= c ^ c_nx;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=13.
// Stimulus pushes expectations; monitors pop them on done.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] d;
    logic        b;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, bo8, ov8;
  logic [7:0]  diff8;

  logic        start13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        busy13, done13, bo13, ov13;
  logic [12:0] diff13;

  exp_t q8[$];
  exp_t q13[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t8    = 0;
  int t13   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13),
    .a(a13), .b(b13), .busy(busy13), .done(done13),
    .diff(diff13), .borrow_out(bo13), .overflow(ov13)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: modular difference, unsigned borrow, signed overflow
  function automatic exp_t model(input int w, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t        e;
    logic [31:0] m;
    m   = (32'd1 << w) - 1;
    x   = x & m;
    y   = y & m;
    e.d = (x - y) & m;
    e.b = (x < y);
    e.o = (x[w-1] != y[w-1]) && (e.d[w-1] != x[w-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL done8_spurious: got done=1 want no done");
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), e.d);
        chk("borrow8", 32'(bo8), 32'(e.b));
        chk("ovf8", 32'(ov8), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    if (done13) begin
      if (q13.size() == 0) begin
        total++; bad++;
        $display("FAIL done13_spurious: got done=1 want no done");
      end else begin
        exp_t e;
        e = q13.pop_front();
        chk("diff13", 32'(diff13), e.d);
        chk("borrow13", 32'(bo13), 32'(e.b));
        chk("ovf13", 32'(ov13), 32'(e.o));
      end
    end
  end

  task automatic issue8(input logic [7:0] x, input logic [7:0] y,
                        input bit push, input logic [7:0] ed,
                        input logic eb, input logic eo);
    start8 = 1'b1;
    a8 = x;
    b8 = y;
    if (push) q8.push_back('{32'(ed), eb, eo});
    @(posedge clk); #1;
    t8 = cyc;
    start8 = 1'b0;
    chk("busy8_after_start", 32'(busy8), 32'd1);
  endtask

  task automatic wait8(input int lat);
    while (!done8 && (cyc - t8) < lat + 6) begin
      @(posedge clk); #1;
    end
    chk("latency8", 32'(cyc - t8), 32'(lat));
    chk("busy8_at_done", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    chk("done8_one_cycle", 32'(done8), 32'd0);
  endtask

  task automatic run13(input logic [12:0] x, input logic [12:0] y);
    start13 = 1'b1;
    a13 = x;
    b13 = y;
    q13.push_back(model(13, 32'(x), 32'(y)));
    @(posedge clk); #1;
    t13 = cyc;
    start13 = 1'b0;
    while (!done13 && (cyc - t13) < 20) begin
      @(posedge clk); #1;
    end
    chk("latency13", 32'(cyc - t13), 32'd13);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(bo8), 32'd0);
    chk("rst_ovf", 32'(ov8), 32'd0);

    issue8(8'd10, 8'd3, 1, 8'h07, 0, 0);
    wait8(8);
    issue8(8'd3, 8'd10, 1, 8'hF9, 1, 0);
    wait8(8);
    issue8(8'hFF, 8'hFF, 1, 8'h00, 0, 0);
    wait8(8);
    issue8(8'h80, 8'h01, 1, 8'h7F, 0, 1);
    wait8(8);
    issue8(8'h7F, 8'hFF, 1, 8'h80, 1, 1);
    wait8(8);

    // start during RUN must not disturb the operation in flight
    issue8(8'd10, 8'd3, 1, 8'h07, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1;
    a8 = 8'h55;
    b8 = 8'h00;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy8_ignored_start", 32'(busy8), 32'd1);
    wait8(8);
    repeat (10) @(posedge clk);
    #1 chk("busy8_not_extended", 32'(busy8), 32'd0);

    // abort mid-operation
    issue8(8'd10, 8'd3, 0, 8'h00, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_borrow", 32'(bo8), 32'd0);
    chk("abort_ovf", 32'(ov8), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    issue8(8'd20, 8'd5, 1, 8'h0F, 0, 0);
    wait8(8);

    // back-to-back with start held high
    start8 = 1'b1;
    a8 = 8'd10;
    b8 = 8'd3;
    q8.push_back('{32'h07, 1'b0, 1'b0});
    @(posedge clk); #1;
    t8 = cyc;
    while (!done8 && (cyc - t8) < 14) begin
      @(posedge clk); #1;
    end
    chk("b2b_latency1", 32'(cyc - t8), 32'd8);
    a8 = 8'd0;
    b8 = 8'd1;
    q8.push_back('{32'hFF, 1'b1, 1'b0});
    @(posedge clk); #1;
    t8 = cyc;
    start8 = 1'b0;
    chk("b2b_busy", 32'(busy8), 32'd1);
    wait8(8);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] x, y;
      exp_t e;
      x = 8'($urandom);
      y = 8'($urandom);
      e = model(8, 32'(x), 32'(y));
      issue8(x, y, 1, e.d[7:0], e.b, e.o);
      wait8(8);
    end

    run13(13'h1000, 13'h0001);
    run13(13'h0000, 13'h1FFF);
    for (int i = 0; i < 200; i++) begin
      run13(13'($urandom), 13'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q13_drained", 32'(q13.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
